// File: rtl/console_pkg.sv
// Shared op-codes, control characters, FSM states and default geometry
// for the text console front end.
package console_pkg;

  localparam logic [1:0] OP_PUTC       = 2'd0;
  localparam logic [1:0] OP_SET_CURSOR = 2'd1;
  localparam logic [1:0] OP_CLEAR      = 2'd2;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLR_LINE   = 2'd1,
    ST_CLR_SCREEN = 2'd2
  } state_t;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 30;
  localparam int DEF_ADDR_W = 12;

endpackage

// File: rtl/console_fill.sv
// Emits `count` ascending space writes from `start_addr`, one per cycle starting the
// cycle after `start`; `done` marks the cycle in which the last write is issued.
module console_fill
  import console_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        dat,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;

  logic              active;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      addr_q <= '0;
      remain <= '0;
    end else if (start) begin
      active <= (count != CNT_ZERO);
      addr_q <= start_addr;
      remain <= count;
    end else if (active) begin
      addr_q <= addr_q + ADDR_ONE;
      remain <= remain - CNT_ONE;
      if (remain == CNT_ONE) active <= 1'b0;
    end
  end

  assign wr   = active;
  assign addr = addr_q;
  assign dat  = CH_SPACE;
  assign done = active && (remain == CNT_ONE);

endmodule

// File: rtl/text_console.sv
// Console command front end: owns the cursor, turns commands into registered
// single-cycle text-RAM writes one cycle after acceptance; cmd_ready drops during fills.
module text_console
  import console_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_data,
  output logic              busy,
  output logic [4:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic [ADDR_W-1:0] text_addr,
  output logic              text_write,
  output logic [7:0]        text_in
);

  localparam logic [4:0]        ROW_MAX     = 5'(ROWS - 1);
  localparam logic [6:0]        COL_MAX     = 7'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LINE_CNT    = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W:0]   LINE_REST   = (ADDR_W+1)'(COLS - 1);
  localparam logic [ADDR_W:0]   SCREEN_REST = (ADDR_W+1)'(ROWS * COLS - 1);

  state_t            state;
  logic              linger;
  logic [4:0]        row;
  logic [6:0]        col;
  logic [ADDR_W-1:0] row_base;

  logic              accept;
  logic [7:0]        ch;
  logic              printable;
  logic              last_row;
  logic [4:0]        adv_row;
  logic [ADDR_W-1:0] adv_base;
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        set_row;
  logic [6:0]        set_col;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_start_addr;
  logic [ADDR_W:0]   fill_count;
  logic              fill_wr;
  logic [ADDR_W-1:0] fill_addr;
  logic [7:0]        fill_dat;
  logic              fill_done;

  logic unused_bits;
  assign unused_bits = &{1'b0, cmd_data[15:13]};

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign cursor_row = row;
  assign cursor_col = col;

  assign accept    = cmd_valid && cmd_ready;
  assign ch        = cmd_data[7:0];
  assign printable = (ch != CH_BS) && (ch != CH_LF) && (ch != CH_CR);
  assign last_row  = (row == ROW_MAX);
  assign adv_row   = last_row ? 5'd0 : row + 5'd1;
  assign adv_base  = last_row ? '0 : row_base + COLS_A;
  assign cur_addr  = row_base + ADDR_W'(col);
  assign set_row   = (cmd_data[12:8] > ROW_MAX) ? ROW_MAX : cmd_data[12:8];
  assign set_col   = (cmd_data[6:0] > COL_MAX) ? COL_MAX : cmd_data[6:0];

  // LF and CLEAR emit their first space on the acceptance edge, so the fill covers the rest;
  // a wrapping character occupies that slot and the fill covers the whole new line.
  always_comb begin
    fill_start      = 1'b0;
    fill_start_addr = '0;
    fill_count      = '0;
    if (accept && cmd_op == OP_PUTC && printable && col == COL_MAX) begin
      fill_start      = 1'b1;
      fill_start_addr = adv_base;
      fill_count      = LINE_CNT;
    end else if (accept && cmd_op == OP_PUTC && ch == CH_LF) begin
      fill_start      = 1'b1;
      fill_start_addr = adv_base + ADDR_ONE;
      fill_count      = LINE_REST;
    end else if (accept && cmd_op == OP_CLEAR) begin
      fill_start      = 1'b1;
      fill_start_addr = ADDR_ONE;
      fill_count      = SCREEN_REST;
    end
  end

  console_fill #(.ADDR_W(ADDR_W)) u_fill (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (fill_start),
    .start_addr (fill_start_addr),
    .count      (fill_count),
    .wr         (fill_wr),
    .addr       (fill_addr),
    .dat        (fill_dat),
    .done       (fill_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      linger     <= 1'b0;
      row        <= '0;
      col        <= '0;
      row_base   <= '0;
      text_write <= 1'b0;
      text_addr  <= '0;
      text_in    <= 8'h00;
    end else begin
      text_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUTC: begin
                if (ch == CH_CR) begin
                  col <= '0;
                end else if (ch == CH_BS) begin
                  if (col != 7'd0) col <= col - 7'd1;
                end else if (ch == CH_LF) begin
                  col        <= '0;
                  row        <= adv_row;
                  row_base   <= adv_base;
                  text_write <= 1'b1;
                  text_addr  <= adv_base;
                  text_in    <= CH_SPACE;
                  linger     <= 1'b1;
                  state      <= ST_CLR_LINE;
                end else begin
                  text_write <= 1'b1;
                  text_addr  <= cur_addr;
                  text_in    <= ch;
                  if (col == COL_MAX) begin
                    col      <= '0;
                    row      <= adv_row;
                    row_base <= adv_base;
                    linger   <= 1'b0;
                    state    <= ST_CLR_LINE;
                  end else begin
                    col <= col + 7'd1;
                  end
                end
              end
              OP_SET_CURSOR: begin
                row      <= set_row;
                col      <= set_col;
                row_base <= ADDR_W'(set_row) * COLS_A;
              end
              OP_CLEAR: begin
                row        <= '0;
                col        <= '0;
                row_base   <= '0;
                text_write <= 1'b1;
                text_addr  <= '0;
                text_in    <= CH_SPACE;
                linger     <= 1'b1;
                state      <= ST_CLR_SCREEN;
              end
              default: ;
            endcase
          end
        end
        ST_CLR_LINE, ST_CLR_SCREEN: begin
          if (fill_wr) begin
            text_write <= 1'b1;
            text_addr  <= fill_addr;
            text_in    <= fill_dat;
          end
          // Fills that began on the acceptance edge hold ready low one extra cycle.
          if (fill_done) begin
            if (!linger) state <= ST_IDLE;
            linger <= 1'b0;
          end else if (!fill_wr) begin
            state  <= ST_IDLE;
            linger <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
